// File: rtl/cpu_status_ctx_unit.sv
// cpu_status_ctx_unit
//   CPU status and flags registers with per-bit masked writes, plus a
//   hardware context stack. irq_entry saves {status,flags} and enters the ISR
//   state. irq_return restores the saved context. Both together tail-chain.
//
//   Status bits: dma_ack 0, irq_en 1, mode 2, paging_en 3, halt 4,
//                displayreg_load 5, dir 7.
//   Flags bits:  zf 0, cf 1, sf 2, of 3. Bits above 3 are general purpose.
//
// Ports
//   clk, arst_n                          clock, async active-low reset
//   status_wr_en/_mask/_data             masked write to status
//   flags_wr_en/_mask/_data              masked write to flags (ALU update)
//   irq_entry, irq_return                push / pop context
//   err_clr                              clears sticky errors
//   status_q, flags_q                    current registers
//   stack_level, stack_full, stack_empty stack occupancy
//   ovf_err, unf_err                     sticky push-full / pop-empty errors
module cpu_status_ctx_unit #(
    parameter int unsigned          STATUS_W    = 8,
    parameter int unsigned          FLAGS_W     = 8,
    parameter int unsigned          STACK_DEPTH = 4,
    parameter logic [STATUS_W-1:0]  STATUS_RSVD = STATUS_W'(8'h40)
) (
    input  logic                               clk,
    input  logic                               arst_n,
    input  logic                               status_wr_en,
    input  logic [STATUS_W-1:0]                status_wr_mask,
    input  logic [STATUS_W-1:0]                status_wr_data,
    input  logic                               flags_wr_en,
    input  logic [FLAGS_W-1:0]                 flags_wr_mask,
    input  logic [FLAGS_W-1:0]                 flags_wr_data,
    input  logic                               irq_entry,
    input  logic                               irq_return,
    input  logic                               err_clr,
    output logic [STATUS_W-1:0]                status_q,
    output logic [FLAGS_W-1:0]                 flags_q,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               ovf_err,
    output logic                               unf_err
);

    localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned CTX_W = STATUS_W + FLAGS_W;

    localparam int unsigned IRQ_EN_BIT = 1;
    localparam int unsigned MODE_BIT   = 2;
    localparam int unsigned HALT_BIT   = 4;

    // Status bits cleared on entering the ISR state
    localparam logic [STATUS_W-1:0] ISR_CLR = (STATUS_W'(1) << IRQ_EN_BIT)
                                            | (STATUS_W'(1) << MODE_BIT)
                                            | (STATUS_W'(1) << HALT_BIT);

    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(STACK_DEPTH);

    // Context storage; contents are don't-care after reset, so no reset here
    logic [CTX_W-1:0]    ctx_mem [STACK_DEPTH];

    logic [IDX_W-1:0]    top_idx;
    logic [IDX_W-1:0]    push_idx;
    logic [CTX_W-1:0]    top_ctx;
    logic [STATUS_W-1:0] top_status;
    logic [FLAGS_W-1:0]  top_flags;

    logic [STATUS_W-1:0] status_d;
    logic [FLAGS_W-1:0]  flags_d;
    logic [LVL_W-1:0]    level_d;
    logic                ovf_d;
    logic                unf_d;
    logic                ovf_new;
    logic                unf_new;
    logic                push_en;

    // Occupancy flags from the registered level
    assign stack_full  = (stack_level == LVL_FULL);
    assign stack_empty = (stack_level == '0);

    // Top entry sits at level-1; index held at 0 when empty to stay in range
    assign top_idx    = stack_empty ? '0 : IDX_W'(stack_level - LVL_ONE);
    assign push_idx   = IDX_W'(stack_level);
    assign top_ctx    = ctx_mem[top_idx];
    assign top_status = top_ctx[CTX_W-1 -: STATUS_W];
    assign top_flags  = top_ctx[FLAGS_W-1:0];

    // Next-state: context operations take priority over register writes
    always_comb begin
        status_d = status_q;
        flags_d  = flags_q;
        level_d  = stack_level;
        ovf_new  = 1'b0;
        unf_new  = 1'b0;
        push_en  = 1'b0;

        if (irq_entry && irq_return && !stack_empty) begin
            // Tail-chain: replace current context with the top entry in ISR state
            status_d = top_status & ~ISR_CLR;
            flags_d  = top_flags;
        end else if (irq_entry) begin
            // Plain entry, or tail-chain on an empty stack
            if (stack_full) begin
                ovf_new = 1'b1;
            end else begin
                push_en = 1'b1;
                level_d = stack_level + LVL_ONE;
            end
            status_d = status_q & ~ISR_CLR;
            if (irq_return) begin
                unf_new = 1'b1;
            end
        end else if (irq_return) begin
            if (stack_empty) begin
                unf_new = 1'b1;
            end else begin
                status_d = top_status;
                flags_d  = top_flags;
                level_d  = stack_level - LVL_ONE;
            end
        end else begin
            if (status_wr_en) begin
                status_d = (status_q & ~status_wr_mask) | (status_wr_data & status_wr_mask);
            end
            if (flags_wr_en) begin
                flags_d = (flags_q & ~flags_wr_mask) | (flags_wr_data & flags_wr_mask);
            end
        end

        // Reserved bits read 0 whatever the source
        status_d = status_d & ~STATUS_RSVD;

        // A new error in the same cycle as err_clr wins
        ovf_d = (ovf_err & ~err_clr) | ovf_new;
        unf_d = (unf_err & ~err_clr) | unf_new;
    end

    // Architectural state
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            status_q    <= '0;
            flags_q     <= '0;
            stack_level <= '0;
            ovf_err     <= 1'b0;
            unf_err     <= 1'b0;
        end else begin
            status_q    <= status_d;
            flags_q     <= flags_d;
            stack_level <= level_d;
            ovf_err     <= ovf_d;
            unf_err     <= unf_d;
        end
    end

    // Context push; suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (push_en && arst_n) begin
            ctx_mem[push_idx] <= {status_q, flags_q};
        end
    end

endmodule
